regfile_writeback_queue: RTL
============================

// Module: regfile_writeback_queue
// PURPOSE
//  Writeback buffer feeding the dual write ports of the 32x32 register file.
//  - Accepts one (index, data) result per cycle from the execute stage.
//  - Holds results in an in-order FIFO.
//  - Drains up to two entries per cycle onto write1/write2.
//  - Never drives the same index on both ports, so no write is silently dropped.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of two, >=2
//  DATA_W  32  write data width
//  IDX_W   5   register index width
// PORTS
//  clk           in   1                  clock; all state updates on posedge
//  clr           in   1                  synchronous active-high reset
//  in_valid      in   1                  producer has a result this cycle
//  in_ready      out  1                  queue can accept (count < DEPTH)
//  in_index      in   IDX_W              destination register index
//  in_data       in   DATA_W             result data
//  drain_en      in   1                  1 = drain allowed this cycle; 0 = hold all entries
//  write1        out  1                  port-1 write strobe to register file
//  write_index1  out  IDX_W              port-1 index (oldest entry)
//  write_data1   out  DATA_W             port-1 data
//  write2        out  1                  port-2 write strobe
//  write_index2  out  IDX_W              port-2 index (second-oldest entry)
//  write_data2   out  DATA_W             port-2 data
//  count         out  $clog2(DEPTH)+1    occupied entries
//  empty, full   out  1                  count==0 / count==DEPTH
// BEHAVIOUR
//  - Reset (clr=1 at posedge):
//    - head, tail and count go to 0; queued entries are discarded.
//    - Next cycle: write1=write2=0, all index/data outputs 0, in_ready=1, empty=1, full=0.
//    - clr overrides any push or drain in the same cycle.
//  - Output timing:
//    - Write outputs are combinational from registered state only (head entries, count, drain_en).
//    - They are stable before the register file's negedge sample.
//  - Push: when in_valid && in_ready at posedge, write entry at tail; tail=(tail+1) mod DEPTH.
//  - in_ready = !full. There is no pass-through when full, even if a pop occurs the same cycle.
//  - Latency: an entry pushed at posedge N appears on write1/write2 no earlier than cycle N+1.
//  - Drain selection, when drain_en=1:
//    - count>=2 && idx[head]!=idx[head+1]: write1=head, write2=head+1; pop 2.
//    - count>=2 && indices equal: write1=head only; pop 1. The younger entry goes out next cycle, preserving order.
//    - count==1: write1=head; pop 1.
//    - count==0 or drain_en=0: write1=write2=0; pop 0.
//  - Inactive ports drive index=0 and data=0.
//  - Count update: count_next = count + push - pops. Simultaneous push and pop is legal at any occupancy except push is blocked when full.
//  - Pointers wrap modulo DEPTH. Entry head+1 wraps too (head=DEPTH-1 pairs with slot 0).
//  - Ordering: entries retire strictly in arrival order; write1 is always older than write2.
// CONFIGURATION
//  ZERO_REG_DROP_EN
//    - Defined:
//      - A push with in_index==0 is accepted (handshake completes) but not stored.
//      - count and tail are unchanged.
//      - Index 0 never appears on write1/write2.
//    - Undefined: index-0 results are queued and written like any other index.
// TESTING
//  1. Reset: clr=1 for 1 cycle with 3 entries queued -> next cycle count=0, empty=1, write1=write2=0, in_ready=1.
//  2. Dual drain: push (2,20), then (3,45), drain_en=1 -> one cycle write1=1 idx2 data20 with write2=1 idx3 data45; then empty.
//  3. Same-index split: queue (2,35), then (2,10) -> cycle A write1 idx2 data35 with write2=0; cycle B write1 idx2 data10; reg2 ends at 10.
//  4. Full/backpressure: drain_en=0, push 8 entries -> full=1, in_ready=0, a 9th push is ignored; drain_en=1 drains 8 in 4 cycles for distinct indices.
//  5. Wrap plus concurrent push/pop: stream 20 distinct-index pushes with drain_en toggling -> every entry retires exactly once, in order, with correct data; count never exceeds 8.
//  6. ZERO_REG_DROP_EN defined: push (0,99), then (4,7) -> only idx4 data7 is written; count peaks at 1. Undefined: idx0 data99 is written first.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// In-order writeback FIFO that drains up to two results per cycle onto the
// register file's dual write ports. Define ZERO_REG_DROP_EN to discard index-0 results.
module regfile_writeback_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IDX_W-1:0]         in_index,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic                     write1,
  output logic [IDX_W-1:0]         write_index1,
  output logic [DATA_W-1:0]        write_data1,
  output logic                     write2,
  output logic [IDX_W-1:0]         write_index2,
  output logic [DATA_W-1:0]        write_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]  idx_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, head_nxt;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, store, pair_ok;
  logic [1:0]        pops;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign head_nxt = head_q + PTR_W'(1);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign count    = count_q;
  assign push     = in_valid && in_ready;

`ifdef ZERO_REG_DROP_EN
  assign store = push && (in_index != '0);
`else
  assign store = push;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    write1       = 1'b0;
    write_index1 = '0;
    write_data1  = '0;
    write2       = 1'b0;
    write_index2 = '0;
    write_data2  = '0;
    pops         = 2'd0;
    pair_ok      = (count_q >= CNT_W'(2)) && (idx_q[head_q] != idx_q[head_nxt]);
    if (drain_en && !empty) begin
      write1       = 1'b1;
      write_index1 = idx_q[head_q];
      write_data1  = data_q[head_q];
      pops         = 2'd1;
      // Same index twice would collide in the register file; hold the younger one.
      if (pair_ok) begin
        write2       = 1'b1;
        write_index2 = idx_q[head_nxt];
        write_data2  = data_q[head_nxt];
        pops         = 2'd2;
      end
    end
    head_d  = head_q + PTR_W'(pops);
    tail_d  = store ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(store) - CNT_W'(pops);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale slots are never seen.
  always_ff @(posedge clk) begin
    if (store && !clr) begin
      idx_q[tail_q]  <= in_index;
      data_q[tail_q] <= in_data;
    end
  end

endmodule
